// File: rtl/piece_dropper_pkg.sv
// Constants shared by the piece dropper, the victory checker and the game controller.
package piece_dropper_pkg;

   localparam logic [1:0] PLAYER_NONE = 2'b00;
   localparam logic [1:0] PLAYER_1    = 2'b01;
   localparam logic [1:0] PLAYER_2    = 2'b10;

   localparam int DEF_ROWS = 8;
   localparam int DEF_COLS = 8;

   typedef enum logic [2:0] {
      DROP_IDLE   = 3'd0,
      DROP_SCAN   = 3'd1,
      DROP_WRITE  = 3'd2,
      DROP_NOTIFY = 3'd3,
      DROP_REJECT = 3'd4
   } drop_state_t;

   function automatic logic is_player(input logic [1:0] p);
      return (p == PLAYER_1) || (p == PLAYER_2);
   endfunction

endpackage

// File: rtl/piece_dropper.sv
// Drops a piece into the lowest empty cell of a column, then hands the move
// to the victory checker; illegal or full-column requests are rejected.
module piece_dropper
   import piece_dropper_pkg::*;
#(
   parameter int NUM_ROWS = DEF_ROWS,
   parameter int NUM_COLS = DEF_COLS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       start,
   input  logic [2:0] col,
   input  logic [1:0] player,
   output logic [2:0] read_row,
   output logic [2:0] read_col,
   input  logic [1:0] data_in,
   output logic       write_en,
   output logic [2:0] write_row,
   output logic [2:0] write_col,
   output logic [1:0] write_data,
   output logic [2:0] move_row,
   output logic [2:0] move_col,
   output logic       check_start,
   output logic       busy,
   output logic       done,
   output logic       rejected,
   output logic [6:0] move_count,
   output logic       board_full
);

   localparam logic [6:0] MAX_MOVES = 7'(NUM_ROWS * NUM_COLS);
   localparam logic [2:0] LAST_ROW  = 3'(NUM_ROWS - 1);
   localparam logic [3:0] COL_LIMIT = 4'(NUM_COLS);

   drop_state_t r_state, w_next;

   logic [2:0] r_col, w_col;
   logic [1:0] r_player, w_player;
   logic [2:0] r_read_row, w_read_row, r_read_col, w_read_col;
   logic [2:0] r_write_row, w_write_row, r_write_col, w_write_col;
   logic [1:0] r_write_data, w_write_data;
   logic [2:0] r_move_row, w_move_row, r_move_col, w_move_col;
   logic [6:0] r_move_count, w_move_count;
   logic       r_board_full, r_write_en, r_check_start, r_busy, r_done, r_rejected;
   logic       w_illegal;

   assign w_illegal = ({1'b0, col} >= COL_LIMIT) || !is_player(player) || r_board_full;

   always_comb begin
      w_next       = r_state;
      w_col        = r_col;
      w_player     = r_player;
      w_read_row   = r_read_row;
      w_read_col   = r_read_col;
      w_write_row  = r_write_row;
      w_write_col  = r_write_col;
      w_write_data = r_write_data;
      w_move_row   = r_move_row;
      w_move_col   = r_move_col;
      w_move_count = r_move_count;
      case (r_state)
         DROP_IDLE: begin
            if (start) begin
               w_col    = col;
               w_player = player;
               if (w_illegal) begin
                  w_next = DROP_REJECT;
               end else begin
                  w_next     = DROP_SCAN;
                  w_read_row = 3'd0;
                  w_read_col = col;
               end
            end else if (new_game) begin
               w_move_count = 7'd0;
               w_move_row   = 3'd0;
               w_move_col   = 3'd0;
            end else begin
               w_next = DROP_IDLE;
            end
         end
         DROP_SCAN: begin
            if (data_in == PLAYER_NONE) begin
               w_next       = DROP_WRITE;
               w_write_row  = r_read_row;
               w_write_col  = r_col;
               w_write_data = r_player;
            end else if (r_read_row == LAST_ROW) begin
               w_next = DROP_REJECT;
            end else begin
               w_read_row = r_read_row + 3'd1;
            end
         end
         DROP_WRITE: begin
            w_next     = DROP_NOTIFY;
            w_move_row = r_write_row;
            w_move_col = r_write_col;
            if (r_move_count != MAX_MOVES) begin
               w_move_count = r_move_count + 7'd1;
            end else begin
               w_move_count = r_move_count;
            end
         end
         DROP_NOTIFY: w_next = DROP_IDLE;
         DROP_REJECT: w_next = DROP_IDLE;
         default:     w_next = DROP_IDLE;
      endcase
   end

   // Pulses are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= DROP_IDLE;
         r_col         <= 3'd0;
         r_player      <= 2'd0;
         r_read_row    <= 3'd0;
         r_read_col    <= 3'd0;
         r_write_row   <= 3'd0;
         r_write_col   <= 3'd0;
         r_write_data  <= 2'd0;
         r_move_row    <= 3'd0;
         r_move_col    <= 3'd0;
         r_move_count  <= 7'd0;
         r_board_full  <= 1'b0;
         r_write_en    <= 1'b0;
         r_check_start <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_rejected    <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_col         <= w_col;
         r_player      <= w_player;
         r_read_row    <= w_read_row;
         r_read_col    <= w_read_col;
         r_write_row   <= w_write_row;
         r_write_col   <= w_write_col;
         r_write_data  <= w_write_data;
         r_move_row    <= w_move_row;
         r_move_col    <= w_move_col;
         r_move_count  <= w_move_count;
         r_board_full  <= (w_move_count == MAX_MOVES);
         r_write_en    <= (w_next == DROP_WRITE);
         r_check_start <= (w_next == DROP_NOTIFY);
         r_busy        <= (w_next != DROP_IDLE);
         r_done        <= (w_next == DROP_NOTIFY) || (w_next == DROP_REJECT);
         r_rejected    <= (w_next == DROP_REJECT);
      end
   end

   assign read_row    = r_read_row;
   assign read_col    = r_read_col;
   assign write_en    = r_write_en;
   assign write_row   = r_write_row;
   assign write_col   = r_write_col;
   assign write_data  = r_write_data;
   assign move_row    = r_move_row;
   assign move_col    = r_move_col;
   assign check_start = r_check_start;
   assign busy        = r_busy;
   assign done        = r_done;
   assign rejected    = r_rejected;
   assign move_count  = r_move_count;
   assign board_full  = r_board_full;

endmodule
